systolic_feeder: RTL and testbench



---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_feeder_fifo.sv | 60 ++++++
 rtl/systolic_feeder.sv | 149 ++++++++++++++
 tb/tb_systolic_feeder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array feeder.
// Holds the feeder FSM encoding and the drain-length helper.
package systolic_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_LANES = 4;

  // Cycles needed to flush the deepest skew lane.
  function automatic int unsigned drain_len(
    input int unsigned lanes
  );
    return 2 * lanes - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_fifo.sv
// Synchronous FIFO buffering operand vectors for the feeder.
// Head is read combinationally; async active-low reset.
module feeder_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wp_d  = push ? inc(wp_q) : wp_q;
    rp_d  = pop  ? inc(rp_q) : rp_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata;
  end

  assign rdata = mem_q[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/systolic_feeder.sv
// Tile feeder: buffers vectors, streams K-vector tiles, then drains.
// SYSTOLIC_FEEDER_STATS_EN adds a 16-bit tile_count output.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned n     = DEF_N,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned K     = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*n-1:0] in_data,
  output logic [LANES*n-1:0] lane_data,
  output logic               lane_valid,
  output logic               tile_start,
  output logic               tile_done,
`ifdef SYSTOLIC_FEEDER_STATS_EN
  output logic [15:0]        tile_count,
`endif
  output logic               busy
);

  localparam int unsigned W    = LANES * n;
  localparam int unsigned D    = drain_len(LANES);
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned BMAX = (K > D) ? K : D;
  localparam int unsigned BW   = $clog2(BMAX + 1);

  feeder_state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [CW-1:0] count;
  logic [W-1:0]  head;
  logic          push, pop;
  logic          start_d, done_d;

  logic [W-1:0]  lane_data_q;
  logic          lane_valid_q;
  logic          tile_start_q;
  logic          tile_done_q;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  feeder_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FILL;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      FILL: begin
        beat_d = '0;
        if (count >= CW'(K)) state_d = STREAM;
      end
      STREAM: begin
        if (beat_q == BW'(K - 1)) begin
          state_d = DRAIN;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      DRAIN: begin
        if (beat_q == BW'(D - 1)) begin
          state_d = FILL;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: begin
        state_d = FILL;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == STREAM): begin
        pop     = 1'b1;
        start_d = (beat_q == '0);
      end
      (state_q == DRAIN): begin
        done_d = (beat_q == BW'(D - 1));
      end
      default: ;
    endcase
  end

  // Padding cycles output zero so the skew chains flush cleanly.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lane_data_q  <= '0;
      lane_valid_q <= 1'b0;
      tile_start_q <= 1'b0;
      tile_done_q  <= 1'b0;
    end else begin
      lane_data_q  <= pop ? head : '0;
      lane_valid_q <= pop;
      tile_start_q <= start_d;
      tile_done_q  <= done_d;
    end
  end

`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [15:0] tile_count_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) tile_count_q <= '0;
    else if (done_d) tile_count_q <= tile_count_q + 16'd1;
  end

  assign tile_count = tile_count_q;
`endif

  assign lane_data  = lane_data_q;
  assign lane_valid = lane_valid_q;
  assign tile_start = tile_start_q;
  assign tile_done  = tile_done_q;
  assign busy       = (state_q != FILL);

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (default parameters).
// Reference model schedules tiles from vector acceptance times.
module tb_systolic_feeder;

  localparam int K     = 4;
  localparam int L     = 4;
  localparam int DEPTH = 8;
  localparam int W     = 16;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic [W-1:0] lane_data;
  logic         lane_valid;
  logic         tile_start;
  logic         tile_done;
  logic         busy;
`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [15:0]  tile_count;
`endif

  systolic_feeder #(
    .n     (4),
    .LANES (L),
    .K     (K),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .tile_start (tile_start),
    .tile_done  (tile_done),
`ifdef SYSTOLIC_FEEDER_STATS_EN
    .tile_count (tile_count),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;
  int nacc  = 0;
  int elast = -1000;

  logic [W-1:0] vecs[$];
  int           ts[$];
  int           te[$];

  logic [W-1:0] ex_d;
  logic         ex_v, ex_s, ex_dn, ex_b;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [W-1:0] ed;
    logic         ev;
    logic         es;
    logic         edn;
    logic         eb;
  } row_t;

  row_t tbl[17];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h",
                  nm, cyc, act, exp);
  endtask

  function automatic int npops(input int c);
    int s = 0;
    foreach (ts[j]) begin
      if (c >= ts[j] + K - 1) s += K;
      else if (c >= ts[j]) s += c - ts[j] + 1;
    end
    return s;
  endfunction

  task automatic model_out(input int c);
    ex_d = '0; ex_v = 0; ex_s = 0; ex_dn = 0; ex_b = 0;
    foreach (ts[j]) begin
      if (c >= ts[j] && c < ts[j] + K) begin
        ex_v = 1;
        ex_d = vecs[j*K + c - ts[j]];
        ex_s = (c == ts[j]);
      end
      if (c == te[j]) ex_dn = 1;
      if (c >= ts[j] - 1 && c < te[j]) ex_b = 1;
    end
  endtask

  task automatic check_outs();
    model_out(cyc);
    chk("lane_data", 32'(lane_data), 32'(ex_d));
    chk("lane_valid", 32'(lane_valid), 32'(ex_v));
    chk("tile_start", 32'(tile_start), 32'(ex_s));
    chk("tile_done", 32'(tile_done), 32'(ex_dn));
    chk("busy", 32'(busy), 32'(ex_b));
  endtask

  task automatic step(input logic v, input logic [W-1:0] d);
    logic rdy;
    int   s;
    in_valid = v;
    in_data  = d;
    rdy = (nacc - npops(cyc)) < DEPTH;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    cyc++;
    if (v && rdy) begin
      vecs.push_back(d);
      nacc++;
      if (nacc % K == 0) begin
        s = ((cyc > elast) ? cyc : elast) + 2;
        ts.push_back(s);
        te.push_back(s + K + 2*L - 2);
        elast = s + K + 2*L - 2;
      end
    end
    check_outs();
  endtask

  task automatic model_clear();
    vecs.delete(); ts.delete(); te.delete();
    nacc = 0; elast = -1000; cyc = 0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  initial begin
    int dens[8] = '{100, 30, 70, 10, 100, 50, 90, 20};
    int guard;

    foreach (tbl[i]) tbl[i] = '{0, 16'h0, 16'h0, 0, 0, 0, 0};
    tbl[0].v = 1; tbl[0].d = 16'h1111;
    tbl[1].v = 1; tbl[1].d = 16'h2222;
    tbl[2].v = 1; tbl[2].d = 16'h3333;
    tbl[3].v = 1; tbl[3].d = 16'h4444;
    for (int i = 4; i <= 14; i++) tbl[i].eb = 1;
    tbl[5].ed = 16'h1111; tbl[5].ev = 1; tbl[5].es = 1;
    tbl[6].ed = 16'h2222; tbl[6].ev = 1;
    tbl[7].ed = 16'h3333; tbl[7].ev = 1;
    tbl[8].ed = 16'h4444; tbl[8].ev = 1;
    tbl[15].edn = 1;

    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    check_outs();
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].d);
      chk("tbl_data", 32'(lane_data), 32'(tbl[i].ed));
      chk("tbl_valid", 32'(lane_valid), 32'(tbl[i].ev));
      chk("tbl_start", 32'(tile_start), 32'(tbl[i].es));
      chk("tbl_done", 32'(tile_done), 32'(tbl[i].edn));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].eb));
    end

    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, W'(16'hA000 + i));
    for (int i = 0; i < 40; i++) step(1'b0, 16'h0);

    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, W'(16'hB000 + i));
    for (int i = 0; i < 30; i++) step(1'b0, 16'h0);
    step(1'b1, 16'hB003);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0);

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, W'(16'hC000 + i));
    guard = 0;
    while (cyc < ts[0] && guard < 10) begin
      step(1'b0, 16'h0);
      guard++;
    end
    chk("reach_stream2", 32'(cyc), 32'(ts[0]));
    #2 nrst = 1'b0;
    #1;
    chk("arst_data", 32'(lane_data), 32'd0);
    chk("arst_valid", 32'(lane_valid), 32'd0);
    chk("arst_start", 32'(tile_start), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b0, 16'h0);
    for (int i = 0; i < 4; i++) step(1'b1, W'(16'hD000 + i));
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0);

    do_reset();
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < dens[p],
             W'($urandom));
    end
    for (int i = 0; i < 40; i++) step(1'b0, 16'h0);

`ifdef SYSTOLIC_FEEDER_STATS_EN
    begin
      int nd = 0;
      foreach (te[j]) if (te[j] <= cyc) nd++;
      chk("tile_count", 32'(tile_count), 32'(nd));
    end
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
